// File: rtl/uart_rom_loader_pkg.sv
// uart_rom_loader_pkg: shared sync/command byte codes and the 3-bit loader FSM state encoding
package uart_rom_loader_pkg;
  localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_RUN = 8'h02;
  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR_H, S_ADDR_L, S_LEN_H, S_LEN_L, S_DATA, S_CSUM
  } state_t;
endpackage

// File: rtl/uart_rom_loader_rx_edge.sv
// loader_rx_edge: rx_valid rising-edge accept strobe (clk, reset, rx_valid, busy -> accept) plus inter-byte timeout counter (-> timeout)
module loader_rx_edge #(
  parameter logic [23:0] TIMEOUT_CLKS = 24'd120000
) (
  input  logic clk,
  input  logic reset,
  input  logic rx_valid,
  input  logic busy,
  output logic accept,
  output logic timeout
);
  logic prev;
  logic [23:0] cnt;
  assign accept = rx_valid & ~prev;
  assign timeout = busy & (cnt >= TIMEOUT_CLKS);
  always_ff @(posedge clk) begin
    prev <= rx_valid;
    if (reset || accept || !busy) cnt <= '0;
    else if (!timeout) cnt <= cnt + 24'd1;
  end
endmodule

// File: rtl/uart_rom_loader.sv
// uart_rom_loader: parses A5/cmd/addr/len/data/csum packets from rx_valid/rx_byte into mem_addr/mem_wdata/mem_we/mem_ready writes, drives cpu_hold/busy/load_done and sticky err_checksum/err_overrun/err_timeout
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE     = SYNC_DEFAULT,
  parameter logic [23:0] TIMEOUT_CLKS  = 24'd120000,
  parameter logic        HOLD_AT_RESET = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic        cpu_hold,
  output logic        busy,
  output logic        load_done,
  output logic        err_checksum,
  output logic        err_overrun,
  output logic        err_timeout
);
  state_t state;
  logic [15:0] len;
  logic [7:0] sum;
  logic accept, timeout;
  assign busy = state != S_IDLE;
  loader_rx_edge #(.TIMEOUT_CLKS(TIMEOUT_CLKS)) u_rx_edge (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .busy(busy),
    .accept(accept), .timeout(timeout)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      cpu_hold <= HOLD_AT_RESET;
      load_done <= 1'b0;
      err_checksum <= 1'b0;
      err_overrun <= 1'b0;
      err_timeout <= 1'b0;
      len <= '0;
      sum <= '0;
    end else begin
      load_done <= 1'b0;
      if (mem_we && mem_ready) begin
        mem_we <= 1'b0;
        mem_addr <= mem_addr + 16'd1;
      end
      if (accept) begin
        case (state)
          S_IDLE: if (rx_byte == SYNC_BYTE) begin
            state <= S_CMD;
            cpu_hold <= 1'b1;
            err_checksum <= 1'b0;
            err_overrun <= 1'b0;
            err_timeout <= 1'b0;
          end
          S_CMD: begin
            state <= rx_byte == CMD_WRITE ? S_ADDR_H : S_IDLE;
            sum <= '0;
            if (rx_byte == CMD_RUN && !(err_checksum || err_overrun || err_timeout)) cpu_hold <= 1'b0;
          end
          S_ADDR_H: begin
            mem_addr[15:8] <= rx_byte;
            sum <= sum + rx_byte;
            state <= S_ADDR_L;
          end
          S_ADDR_L: begin
            mem_addr[7:0] <= rx_byte;
            sum <= sum + rx_byte;
            state <= S_LEN_H;
          end
          S_LEN_H: begin
            len[15:8] <= rx_byte;
            sum <= sum + rx_byte;
            state <= S_LEN_L;
          end
          S_LEN_L: begin
            len[7:0] <= rx_byte;
            sum <= sum + rx_byte;
            state <= {len[15:8], rx_byte} == 16'd0 ? S_CSUM : S_DATA;
          end
          S_DATA: begin
            // a completing write this cycle leaves room for the new byte, so only a stalled write overruns
            if (mem_we && !mem_ready) err_overrun <= 1'b1;
            mem_wdata <= rx_byte;
            mem_we <= 1'b1;
            len <= len - 16'd1;
            sum <= sum + rx_byte;
            if (len == 16'd1) state <= S_CSUM;
          end
          default: begin
            if (sum + rx_byte == 8'd0) load_done <= 1'b1;
            else err_checksum <= 1'b1;
            state <= S_IDLE;
          end
        endcase
      end else if (timeout) begin
        err_timeout <= 1'b1;
        state <= S_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_uart_rom_loader.sv
// tb_uart_rom_loader: scoreboard bench checking writes, load_done, cpu_hold and error flags of uart_rom_loader
module tb_uart_rom_loader;
  localparam int TO = 200;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rx_valid = 1'b0;
  logic [7:0] rx_byte = '0;
  logic mem_ready = 1'b1;
  logic [15:0] mem_addr;
  logic [7:0] mem_wdata;
  logic mem_we, cpu_hold, busy, load_done, err_checksum, err_overrun, err_timeout;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  logic [23:0] exp_q[$];
  logic [7:0] data_q[$];
  uart_rom_loader #(.TIMEOUT_CLKS(24'(TO))) dut (
    .clk(clk), .reset(reset), .rx_valid(rx_valid), .rx_byte(rx_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_ready(mem_ready),
    .cpu_hold(cpu_hold), .busy(busy), .load_done(load_done),
    .err_checksum(err_checksum), .err_overrun(err_overrun), .err_timeout(err_timeout)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) if (!reset) begin
    logic [23:0] e;
    if (load_done) done_cnt++;
    if (mem_we && mem_ready) begin
      if (exp_q.size() == 0) chk("wr_extra", {8'h0, mem_addr, mem_wdata}, 32'h0);
      else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e[23:8]));
        chk("wr_data", 32'(mem_wdata), 32'(e[7:0]));
      end
    end
  end
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic send_b(input logic [7:0] b, input int hold = 1);
    rx_byte = b;
    rx_valid = 1'b1;
    repeat (hold) tick();
    rx_valid = 1'b0;
    repeat (3) tick();
  endtask
  function automatic logic [7:0] calc_csum(input logic [15:0] addr);
    logic [7:0] s;
    s = addr[15:8] + addr[7:0] + 8'(data_q.size() >> 8) + 8'(data_q.size());
    foreach (data_q[i]) s = s + data_q[i];
    return 8'(-s);
  endfunction
  task automatic send_hdr(input logic [15:0] addr, input int hold = 1);
    send_b(8'hA5, hold);
    send_b(8'h01, hold);
    send_b(addr[15:8], hold);
    send_b(addr[7:0], hold);
    send_b(8'(data_q.size() >> 8), hold);
    send_b(8'(data_q.size()), hold);
  endtask
  task automatic send_pkt(input logic [15:0] addr, input bit bad);
    logic [15:0] a;
    logic [7:0] c;
    a = addr;
    c = calc_csum(addr);
    send_hdr(addr);
    foreach (data_q[i]) begin
      exp_q.push_back({a, data_q[i]});
      a = a + 16'd1;
      send_b(data_q[i]);
    end
    send_b(bad ? c + 8'd1 : c);
  endtask
  initial begin
    int d0;
    logic [7:0] c;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_hold", 32'(cpu_hold), 32'h1);
    chk("rst_errs", {29'h0, err_checksum, err_overrun, err_timeout}, 32'h0);
    d0 = done_cnt;
    data_q = {8'h11, 8'h22, 8'h33};
    send_pkt(16'hC000, 1'b0);
    chk("t1_done", 32'(done_cnt - d0), 32'h1);
    chk("t1_hold", 32'(cpu_hold), 32'h1);
    chk("t1_errs", {29'h0, err_checksum, err_overrun, err_timeout}, 32'h0);
    chk("t1_busy", 32'(busy), 32'h0);
    d0 = done_cnt;
    send_pkt(16'hC000, 1'b1);
    chk("t2_done", 32'(done_cnt - d0), 32'h0);
    chk("t2_cerr", 32'(err_checksum), 32'h1);
    send_b(8'hA5);
    chk("t2_clr", 32'(err_checksum), 32'h0);
    send_b(8'h02);
    chk("t2_run", 32'(cpu_hold), 32'h0);
    d0 = done_cnt;
    data_q = {8'hAA, 8'hBB};
    send_pkt(16'hFFFF, 1'b0);
    chk("t3_done", 32'(done_cnt - d0), 32'h1);
    chk("t3_cerr", 32'(err_checksum), 32'h0);
    chk("t3_hold", 32'(cpu_hold), 32'h1);
    data_q = {8'h55, 8'h66};
    c = calc_csum(16'h1000);
    send_hdr(16'h1000);
    mem_ready = 1'b0;
    send_b(8'h55);
    chk("t4_ovr0", 32'(err_overrun), 32'h0);
    send_b(8'h66);
    exp_q.push_back({16'h1000, 8'h66});
    send_b(c);
    chk("t4_ovr", 32'(err_overrun), 32'h1);
    chk("t4_held", 32'(mem_we), 32'h1);
    chk("t4_wdata", 32'(mem_wdata), 32'h66);
    mem_ready = 1'b1;
    repeat (3) tick();
    chk("t4_we_low", 32'(mem_we), 32'h0);
    chk("t4_addr", 32'(mem_addr), 32'h1001);
    send_b(8'hA5);
    send_b(8'h01);
    send_b(8'hC0);
    repeat (TO / 2) tick();
    chk("t5_early", 32'(err_timeout), 32'h0);
    chk("t5_busy1", 32'(busy), 32'h1);
    repeat (TO + 5) tick();
    chk("t5_terr", 32'(err_timeout), 32'h1);
    chk("t5_busy0", 32'(busy), 32'h0);
    chk("t5_we", 32'(mem_we), 32'h0);
    send_b(8'hA5);
    chk("t5_clr", 32'(err_timeout), 32'h0);
    send_b(8'h00);
    chk("t5_idle", 32'(busy), 32'h0);
    data_q = {8'h01, 8'h02, 8'h03};
    send_hdr(16'h2000, 3);
    exp_q.push_back({16'h2000, 8'h01});
    send_b(8'h01, 3);
    exp_q.push_back({16'h2001, 8'h02});
    send_b(8'h02, 3);
    chk("t6_addr", 32'(mem_addr), 32'h2002);
    chk("t6_busy1", 32'(busy), 32'h1);
    rx_byte = 8'h03;
    rx_valid = 1'b1;
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    tick();
    rx_valid = 1'b0;
    repeat (3) tick();
    chk("t6_we", 32'(mem_we), 32'h0);
    chk("t6_busy0", 32'(busy), 32'h0);
    chk("t6_hold", 32'(cpu_hold), 32'h1);
    chk("t6_raddr", 32'(mem_addr), 32'h0);
    chk("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
